// File: rtl/crt_sync_generator.sv
`default_nettype none
// ============================================================================
//  Module      : crt_sync_generator
//  Description : VGA raster timing generator (640x480@60 by default). Runs on
//                the system Clock and treats every rising edge of the divided
//                PixelClock level as one pixel tick. Produces active-low
//                horizontal/vertical sync, a visible-area flag and the current
//                pixel coordinates, all aligned to the same Clock cycle.
//
//  Ports       : Clock      in   system clock, single clock domain
//                Reset      in   synchronous, active-high reset
//                PixelClock in   divided pixel clock level (Clock-synchronous)
//                HSync      out  horizontal sync, active low
//                VSync      out  vertical sync, active low
//                VideoOn    out  high while (PixelX, PixelY) is visible
//                PixelX     out  horizontal count, 0 .. line total - 1
//                PixelY     out  vertical count, 0 .. frame total - 1
//                FrameStart out  one-Clock pulse on the (last,last)->(0,0) move
//
//  Build macro : CRT_FRAME_PULSE_EN - when defined, FrameStart is generated;
//                otherwise FrameStart is tied low (port still present).
//
//  Revision    : 1.0 - initial release
// ============================================================================
module crt_sync_generator #(
    parameter int CounterSize = 10,
    parameter int HActive     = 640,
    parameter int HFront      = 16,
    parameter int HSyncW      = 96,
    parameter int HBack       = 48,
    parameter int VActive     = 480,
    parameter int VFront      = 10,
    parameter int VSyncW      = 2,
    parameter int VBack       = 33
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   PixelClock,
    output logic                   HSync,
    output logic                   VSync,
    output logic                   VideoOn,
    output logic [CounterSize-1:0] PixelX,
    output logic [CounterSize-1:0] PixelY,
    output logic                   FrameStart
);

    localparam logic [CounterSize-1:0] c_one        = CounterSize'(1);
    localparam logic [CounterSize-1:0] c_hLast      = CounterSize'(HActive + HFront + HSyncW + HBack - 1);
    localparam logic [CounterSize-1:0] c_vLast      = CounterSize'(VActive + VFront + VSyncW + VBack - 1);
    localparam logic [CounterSize-1:0] c_hActive    = CounterSize'(HActive);
    localparam logic [CounterSize-1:0] c_vActive    = CounterSize'(VActive);
    localparam logic [CounterSize-1:0] c_hSyncStart = CounterSize'(HActive + HFront);
    localparam logic [CounterSize-1:0] c_hSyncEnd   = CounterSize'(HActive + HFront + HSyncW - 1);
    localparam logic [CounterSize-1:0] c_vSyncStart = CounterSize'(VActive + VFront);
    localparam logic [CounterSize-1:0] c_vSyncEnd   = CounterSize'(VActive + VFront + VSyncW - 1);

    logic                   r_pixelClockQ;
    logic                   w_tick;
    logic                   w_hWrap;
    logic                   w_vWrap;
    logic [CounterSize-1:0] r_pixelX;
    logic [CounterSize-1:0] r_pixelY;
    logic [CounterSize-1:0] w_nextX;
    logic [CounterSize-1:0] w_nextY;
    logic                   r_hSync;
    logic                   r_vSync;
    logic                   r_videoOn;

    // One Clock cycle per PixelClock rising edge.
    assign w_tick = PixelClock & ~r_pixelClockQ;

    always_comb begin
        w_hWrap = (r_pixelX == c_hLast);
        w_vWrap = (r_pixelY == c_vLast);
        w_nextX = r_pixelX;
        w_nextY = r_pixelY;
        if (w_tick) begin
            if (w_hWrap) begin
                w_nextX = '0;
                w_nextY = w_vWrap ? '0 : (r_pixelY + c_one);
            end else begin
                w_nextX = r_pixelX + c_one;
            end
        end
    end

    // Decode is taken from the next counter values so sync/visible flags
    // line up with PixelX/PixelY in the same cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            // Q resets high: a PixelClock already high at release is not a tick.
            r_pixelClockQ <= 1'b1;
            r_pixelX      <= '0;
            r_pixelY      <= '0;
            r_hSync       <= 1'b1;
            r_vSync       <= 1'b1;
            r_videoOn     <= 1'b1;
        end else begin
            r_pixelClockQ <= PixelClock;
            r_pixelX      <= w_nextX;
            r_pixelY      <= w_nextY;
            r_hSync       <= !((w_nextX >= c_hSyncStart) && (w_nextX <= c_hSyncEnd));
            r_vSync       <= !((w_nextY >= c_vSyncStart) && (w_nextY <= c_vSyncEnd));
            r_videoOn     <= (w_nextX < c_hActive) && (w_nextY < c_vActive);
        end
    end

    assign PixelX  = r_pixelX;
    assign PixelY  = r_pixelY;
    assign HSync   = r_hSync;
    assign VSync   = r_vSync;
    assign VideoOn = r_videoOn;

`ifdef CRT_FRAME_PULSE_EN
    logic r_frameStart;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_frameStart <= 1'b0;
        end else begin
            r_frameStart <= w_tick & w_hWrap & w_vWrap;
        end
    end

    assign FrameStart = r_frameStart;
`else
    assign FrameStart = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crt_sync_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crt_sync_generator
//  Description : Self-checking bench for crt_sync_generator. A reduced-timing
//                instance (32 x 19 raster) exercises full frames; a default
//                640x480 instance runs alongside on the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crt_sync_generator;

    localparam int SH_A = 16, SH_F = 4, SH_S = 8, SH_B = 4;
    localparam int SV_A = 12, SV_F = 2, SV_S = 2, SV_B = 3;
    localparam int S_LINE  = SH_A + SH_F + SH_S + SH_B;   // 32
    localparam int S_FRAME = SV_A + SV_F + SV_S + SV_B;   // 19
    localparam int S_TICKS = S_LINE * S_FRAME;            // 608
    localparam int D_LINE  = 800;
    localparam int D_FRAME = 525;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       PixelClock = 1'b1;

    logic       sHSync, sVSync, sVideoOn, sFrameStart;
    logic [9:0] sPixelX, sPixelY;
    logic       dHSync, dVSync, dVideoOn, dFrameStart;
    logic [9:0] dPixelX, dPixelY;

    crt_sync_generator #(
        .CounterSize(10),
        .HActive(SH_A), .HFront(SH_F), .HSyncW(SH_S), .HBack(SH_B),
        .VActive(SV_A), .VFront(SV_F), .VSyncW(SV_S), .VBack(SV_B)
    ) dutSmall (
        .Clock(Clock), .Reset(Reset), .PixelClock(PixelClock),
        .HSync(sHSync), .VSync(sVSync), .VideoOn(sVideoOn),
        .PixelX(sPixelX), .PixelY(sPixelY), .FrameStart(sFrameStart)
    );

    crt_sync_generator dutDefault (
        .Clock(Clock), .Reset(Reset), .PixelClock(PixelClock),
        .HSync(dHSync), .VSync(dVSync), .VideoOn(dVideoOn),
        .PixelX(dPixelX), .PixelY(dPixelY), .FrameStart(dFrameStart)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: number of pixel ticks since reset; coordinates follow
    // by division/modulo of the raster totals.
    int  tS = 0, tD = 0;
    bit  prevPc = 1'b1;
    bit  lastTick = 1'b0;
    bit  expFsS = 1'b0, expFsD = 1'b0;

    // Frame-run statistics
    bit  collect = 1'b0;
    int  hLow = 0, vLow = 0, visCnt = 0, fsCount = 0, fsPrevT = 0, fsGap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compareInst(input string tag, input int t, input int line, input int frame,
                               input int hA, input int hF, input int hS,
                               input int vA, input int vF, input int vS, input bit expFs,
                               input logic h, input logic v, input logic on,
                               input logic [9:0] px, input logic [9:0] py, input logic fs);
        int x;
        int y;
        x = t % line;
        y = (t / line) % frame;
        check({tag, "PixelX"}, 32'(px), 32'(x));
        check({tag, "PixelY"}, 32'(py), 32'(y));
        check({tag, "HSync"}, 32'(h), (x >= hA + hF && x < hA + hF + hS) ? 32'd0 : 32'd1);
        check({tag, "VSync"}, 32'(v), (y >= vA + vF && y < vA + vF + vS) ? 32'd0 : 32'd1);
        check({tag, "VideoOn"}, 32'(on), (x < hA && y < vA) ? 32'd1 : 32'd0);
        check({tag, "FrameStart"}, 32'(fs), 32'(expFs));
    endtask

    task automatic modelStep(input bit rst, input bit pc);
        expFsS = 1'b0;
        expFsD = 1'b0;
        lastTick = 1'b0;
        if (rst) begin
            tS = 0;
            tD = 0;
            prevPc = 1'b1;
        end else begin
            lastTick = pc && !prevPc;
            prevPc = pc;
            if (lastTick) begin
                tS++;
                tD++;
`ifdef CRT_FRAME_PULSE_EN
                expFsS = (tS % S_TICKS) == 0;
                expFsD = (tD % (D_LINE * D_FRAME)) == 0;
`endif
            end
        end
    endtask

    task automatic step(input bit rst, input bit pc);
        Reset = rst;
        PixelClock = pc;
        @(posedge Clock);
        #1;
        modelStep(rst, pc);
        compareInst("s", tS, S_LINE, S_FRAME, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S, expFsS,
                    sHSync, sVSync, sVideoOn, sPixelX, sPixelY, sFrameStart);
        compareInst("d", tD, D_LINE, D_FRAME, 640, 16, 96, 480, 10, 2, expFsD,
                    dHSync, dVSync, dVideoOn, dPixelX, dPixelY, dFrameStart);
        if (collect) begin
            if (lastTick && tS <= S_LINE && sHSync === 1'b0) hLow++;
            if (lastTick && tS <= S_TICKS && sVSync === 1'b0) vLow++;
            if (lastTick && tS <= S_TICKS && sVideoOn === 1'b1) visCnt++;
            if (sFrameStart === 1'b1) begin
                fsCount++;
                if (fsPrevT > 0) fsGap = tS - fsPrevT;
                fsPrevT = tS;
            end
        end
    endtask

    // PixelClock = Clock/4: one tick per call.
    task automatic tickOnce();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    typedef struct {
        bit rst;
        bit pc;
        int x;
        int y;
        bit h;
        bit v;
        bit on;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // Reset sequence and first ticks on the reduced raster
        tbl[0]  = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1, 0, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 2, 0, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 3, 0, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1};

        // Reset held with PixelClock high: nothing advances
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        check("resetX", 32'(sPixelX), 32'd0);
        check("resetFrameStart", 32'(sFrameStart), 32'd0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].pc);
            check($sformatf("vec%0d_X", i), 32'(sPixelX), 32'(tbl[i].x));
            check($sformatf("vec%0d_Y", i), 32'(sPixelY), 32'(tbl[i].y));
            check($sformatf("vec%0d_H", i), 32'(sHSync), 32'(tbl[i].h));
            check($sformatf("vec%0d_V", i), 32'(sVSync), 32'(tbl[i].v));
            check($sformatf("vec%0d_On", i), 32'(sVideoOn), 32'(tbl[i].on));
        end

        // Two full reduced frames at Clock/4
        step(1'b1, 1'b1);
        collect = 1'b1;
        for (int k = 0; k < 2 * S_TICKS; k++) tickOnce();
        collect = 1'b0;
        check("lineHSyncLowTicks", 32'(hLow), 32'(SH_S));
        check("frameVSyncLowTicks", 32'(vLow), 32'(SV_S * S_LINE));
        check("frameVisibleTicks", 32'(visCnt), 32'(SH_A * SV_A));
        check("frameEndX", 32'(sPixelX), 32'd0);
        check("frameEndY", 32'(sPixelY), 32'd0);
`ifdef CRT_FRAME_PULSE_EN
        check("frameStartPulses", 32'(fsCount), 32'd2);
        check("frameStartGap", 32'(fsGap), 32'(S_TICKS));
`else
        check("frameStartPulses", 32'(fsCount), 32'd0);
        check("frameStartGap", 32'(fsGap), 32'd0);
`endif

        // Freeze mid-line: PixelClock held low for 50 cycles
        for (int k = 0; k < 200 && (tS % S_LINE) != 10; k++) tickOnce();
        for (int k = 0; k < 50; k++) step(1'b0, 1'b0);
        check("freezeX", 32'(sPixelX), 32'd10);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        check("releaseX", 32'(sPixelX), 32'd13);

        // Reset in the middle of the sync pulse, on a later line
        for (int k = 0; k < 200 && !((tS % S_LINE) == 26 && (tS / S_LINE) % S_FRAME > 0); k++)
            tickOnce();
        check("preResetHSync", 32'(sHSync), 32'd0);
        step(1'b1, 1'b1);
        check("midResetX", 32'(sPixelX), 32'd0);
        check("midResetY", 32'(sPixelY), 32'd0);
        check("midResetHSync", 32'(sHSync), 32'd1);
        step(1'b0, 1'b1);
        check("noTickAfterReset", 32'(sPixelX), 32'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("resumeX", 32'(sPixelX), 32'd1);

        // Random PixelClock with rare resets
        for (int k = 0; k < 20000; k++)
            step(($urandom_range(0, 999) == 0), 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL timeout: simulation did not reach the end");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/crt_sync_generator.md
# crt_sync_generator

Generates VGA 640x480@60 raster timing: horizontal sync, vertical sync, visible-area flag and current pixel coordinates. It consumes the divided `PixelClock` produced by the CRT clock generator and treats each of its rising edges as a pixel tick, running entirely on the system `Clock`. Its outputs feed the Pong renderer (ball/paddle pixel logic) and the VGA connector pins.

## Interface
Parameters:
- `CounterSize`, 10, width of the horizontal and vertical counters and the coordinate outputs.
- `HActive` / `HFront` / `HSyncW` / `HBack`, 640 / 16 / 96 / 48, horizontal timing in pixel ticks (line total 800).
- `VActive` / `VFront` / `VSyncW` / `VBack`, 480 / 10 / 2 / 33, vertical timing in lines (frame total 525).

Ports:
- `Clock` in 1: system clock. The single clock domain.
- `Reset` in 1: synchronous, active-high reset.
- `PixelClock` in 1: divided pixel clock level from the CRT clock generator, synchronous to `Clock`.
- `HSync` out 1: horizontal sync, active low.
- `VSync` out 1: vertical sync, active low.
- `VideoOn` out 1: high while (`PixelX`, `PixelY`) is inside the visible area.
- `PixelX` out `CounterSize`: horizontal count, 0..799.
- `PixelY` out `CounterSize`: vertical count, 0..524.
- `FrameStart` out 1: one-`Clock` pulse when a new frame begins (see Configuration).

## Operation
- Tick detection:
  - `PixelClockQ` registers `PixelClock` every `Clock` edge.
  - `Tick = PixelClock & ~PixelClockQ`, i.e. exactly one `Clock` cycle per `PixelClock` rising edge.
- Horizontal counter: on `Tick`, `PixelX` increments. When `PixelX` equals the line total minus 1 (799), it wraps to 0.
- Vertical counter:
  - `PixelY` increments only on a `Tick` where `PixelX` wraps.
  - When `PixelY` equals the frame total minus 1 (524) and `PixelX` wraps, `PixelY` wraps to 0.
- Decode. All of the following are registered from the *next* counter values, so they always match `PixelX`/`PixelY` in the same cycle:
  - `HSync` = 0 when `PixelX` is in [`HActive+HFront`, `HActive+HFront+HSyncW-1`] = [656, 751].
  - `VSync` = 0 when `PixelY` is in [490, 491].
  - `VideoOn` = (`PixelX` < 640) && (`PixelY` < 480).
- Widths: all comparisons are unsigned at `CounterSize` bits. Parameter sums must fit in `CounterSize`; this is not checked in RTL.
- No `Tick` means nothing advances. A `PixelClock` held at a constant level freezes all outputs.

## Timing
- Reset values (synchronous, on the first `Clock` edge with `Reset`=1):
  - `PixelX`=0, `PixelY`=0.
  - `HSync`=1, `VSync`=1, `VideoOn`=1 (the decode of (0,0)).
  - `FrameStart`=0.
  - `PixelClockQ`=1, so no spurious tick is seen at reset release if `PixelClock` is already high.
- Latency: counters and decoded outputs update on the `Clock` edge at which `Tick`=1. That is the first `Clock` edge that samples `PixelClock` high after it was low, so the latency is 1 `Clock` from the `PixelClock` rise.
- Reset mid-line or mid-frame: reset takes priority over `Tick`, and the block restarts from (0,0) on the next edge.
- Simultaneous horizontal and vertical wrap at (799, 524): both counters go to 0 on the same edge.
- `PixelClock` at the `Clock` frequency (no low phase) produces no ticks after the first rise. The supported range is `PixelClock` period ≥ 2 `Clock`.

## Configuration
- `CRT_FRAME_PULSE_EN` defined:
  - `FrameStart` is registered high for exactly one `Clock` cycle, coincident with the edge where the counters move from (799, 524) to (0, 0).
  - It is not asserted by reset.
- `CRT_FRAME_PULSE_EN` undefined: `FrameStart` is tied to 0. The port is still present.

## Test plan
- Reset with `PixelClock`=1 held high for 10 `Clock` cycles -> `PixelX`=0, `PixelY`=0, `HSync`=1, `VSync`=1, `VideoOn`=1, `FrameStart`=0, with no advance.
- `PixelClock` = `Clock`/4 (100→25 MHz), run one line -> `VideoOn` drops at `PixelX`=640; `HSync`=0 for exactly 96 ticks from `PixelX`=656 to 751; `PixelY` goes to 1 after the 800th tick.
- Run a full frame -> `VSync`=0 only for `PixelY` 490–491 (1600 ticks); 420000 ticks per frame; counters return to (0,0).
- With `CRT_FRAME_PULSE_EN` defined, run 2 frames -> exactly 2 single-cycle `FrameStart` pulses, 420000 ticks apart. Undefined -> `FrameStart` stays 0 throughout.
- Assert `Reset` for 1 cycle at `PixelX`=700, `PixelY`=300 -> next edge gives (0,0), `HSync`=1; counting resumes from 0 at the next `PixelClock` rise.
- Hold `PixelClock`=0 for 50 `Clock` cycles mid-line -> all outputs frozen; on release, advance by exactly 1 per rise.
